// File: rtl/led_mode_ctrl.sv
// Key-driven LED sequencer: debounced keys select mode (OFF/ON/BLINK/CHASE) and step rate.
// Optional macro LED_LONGPRESS_EN: holding key0 for 1000 ms restores OFF mode and the default rate.
module led_mode_ctrl #(
  parameter int clk_frequency = 27_000_000,
  parameter int io_num        = 1,
  parameter int debounce_ms   = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        key,
  output logic [io_num-1:0] led_o,
  output logic [1:0]        mode_o,
  output logic [1:0]        rate_o
);

  localparam int TICK_CYC = clk_frequency / 1000;
  localparam int TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam int DW = (debounce_ms > 1) ? $clog2(debounce_ms + 1) : 1;
  localparam int PW = (io_num > 1) ? $clog2(io_num) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYC - 1);
  localparam logic [DW-1:0] DB_MAX   = DW'(debounce_ms - 1);
  localparam logic [PW-1:0] POS_MAX  = PW'(io_num - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CHASE = 2'd3
  } mode_t;

  logic [TW-1:0]     r_presc;
  logic [1:0]        r_key_meta;
  logic [1:0]        r_key_sync;
  logic [1:0]        r_key_stable;
  logic [DW-1:0]     r_db_cnt [2];
  logic [1:0]        r_press;
  mode_t             r_mode;
  logic [1:0]        r_rate;
  logic [9:0]        r_step_cnt;
  logic              r_phase;
  logic [PW-1:0]     r_pos;
  logic [io_num-1:0] r_led;

  logic              w_tick;
  logic              w_step;
  logic              w_lp_fire;
  logic [9:0]        w_period_m1;
  logic [io_num-1:0] w_led;

  assign w_tick = (r_presc == TICK_MAX);
  assign w_step = w_tick && (r_step_cnt == w_period_m1);

  // Free-running 1 ms prescaler
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + TW'(1);
    end
  end

  // Two-stage synchronizer, then per-key debounce; press pulse coincides with the stable update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta   <= 2'b11;
      r_key_sync   <= 2'b11;
      r_key_stable <= 2'b11;
      r_db_cnt[0]  <= '0;
      r_db_cnt[1]  <= '0;
      r_press      <= 2'b00;
    end else begin
      r_key_meta <= key;
      r_key_sync <= r_key_meta;
      for (int i = 0; i < 2; i++) begin
        r_press[i] <= 1'b0;
        if (r_key_sync[i] == r_key_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_tick) begin
          if (r_db_cnt[i] == DB_MAX) begin
            r_key_stable[i] <= r_key_sync[i];
            r_db_cnt[i]     <= '0;
            r_press[i]      <= ~r_key_sync[i];
          end else begin
            r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
          end
        end
      end
    end
  end

`ifdef LED_LONGPRESS_EN
  localparam logic [9:0] LP_MAX = 10'd1000;
  logic [9:0] r_lp_cnt;
  logic       r_lp_fire;

  // Long-press counter saturates at LP_MAX so it fires only once per hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lp_cnt  <= 10'd0;
      r_lp_fire <= 1'b0;
    end else begin
      r_lp_fire <= 1'b0;
      if (r_key_stable[0]) begin
        r_lp_cnt <= 10'd0;
      end else if (w_tick && (r_lp_cnt != LP_MAX)) begin
        r_lp_cnt <= r_lp_cnt + 10'd1;
        if (r_lp_cnt == LP_MAX - 10'd1) begin
          r_lp_fire <= 1'b1;
        end
      end
    end
  end

  assign w_lp_fire = r_lp_fire;
`else
  assign w_lp_fire = 1'b0;
`endif

  // Step period in ms minus one: 125 << rate
  always_comb begin
    w_period_m1 = 10'd999;
    case (r_rate)
      2'd0:    w_period_m1 = 10'd124;
      2'd1:    w_period_m1 = 10'd249;
      2'd2:    w_period_m1 = 10'd499;
      default: w_period_m1 = 10'd999;
    endcase
  end

  // Mode/rate FSM and step-driven display state; any setting change restarts the display
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode     <= MODE_OFF;
      r_rate     <= 2'd2;
      r_step_cnt <= 10'd0;
      r_phase    <= 1'b1;
      r_pos      <= '0;
    end else if (w_lp_fire) begin
      r_mode     <= MODE_OFF;
      r_rate     <= 2'd2;
      r_step_cnt <= 10'd0;
      r_phase    <= 1'b1;
      r_pos      <= '0;
    end else if (r_press != 2'b00) begin
      if (r_press[0]) begin
        r_mode <= mode_t'(r_mode + 2'd1);
      end
      if (r_press[1]) begin
        r_rate <= r_rate + 2'd1;
      end
      r_step_cnt <= 10'd0;
      r_phase    <= 1'b1;
      r_pos      <= '0;
    end else begin
      if (w_step) begin
        r_step_cnt <= 10'd0;
        r_phase    <= ~r_phase;
        r_pos      <= (r_pos == POS_MAX) ? '0 : r_pos + PW'(1);
      end else if (w_tick) begin
        r_step_cnt <= r_step_cnt + 10'd1;
      end
    end
  end

  // LED pattern for the current display state
  always_comb begin
    w_led = '0;
    case (r_mode)
      MODE_OFF:   w_led = '0;
      MODE_ON:    w_led = '1;
      MODE_BLINK: w_led = {io_num{r_phase}};
      MODE_CHASE: begin
        for (int i = 0; i < io_num; i++) begin
          w_led[i] = (PW'(i) == r_pos);
        end
      end
      default:    w_led = '0;
    endcase
  end

  // Registered LED drive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= w_led;
    end
  end

  assign led_o  = r_led;
  assign mode_o = r_mode;
  assign rate_o = r_rate;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Directed self-checking bench for led_mode_ctrl (10 clk per ms, 4 LEDs, 2 ms debounce).
module tb_led_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic [3:0] led_o;
  logic [1:0] mode_o;
  logic [1:0] rate_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_mode_ctrl #(
    .clk_frequency(10_000),
    .io_num(4),
    .debounce_ms(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key(key),
    .led_o(led_o),
    .mode_o(mode_o),
    .rate_o(rate_o)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    key   = 2'b11;
    rst_n = 1'b0;
    cyc(5);
    rst_n = 1'b1;
    cyc(2);
  endtask

  // mask bit set = key pressed for 5 ms, then released for 5 ms
  task automatic press(input logic [1:0] mask);
    key = ~mask;
    cyc(50);
    key = 2'b11;
    cyc(50);
  endtask

  task automatic wait_led_change(input int budget, output int n);
    logic [3:0] prev;
    prev = led_o;
    n = 0;
    while (led_o === prev && n < budget) begin
      cyc(1);
      n++;
    end
    if (led_o === prev) begin
      checks++;
      errors++;
      $display("FAIL led_change_timeout: led_o=%b unchanged after %0d cycles", led_o, budget);
    end
  endtask

  task automatic test_reset;
    key   = 2'b11;
    rst_n = 1'b0;
    cyc(5);
    checks++; if (led_o !== 4'b0000) begin errors++; $display("FAIL reset_led: got %b expected 0000", led_o); end
    checks++; if (mode_o !== 2'd0) begin errors++; $display("FAIL reset_mode: got %0d expected 0", mode_o); end
    checks++; if (rate_o !== 2'd2) begin errors++; $display("FAIL reset_rate: got %0d expected 2", rate_o); end
    rst_n = 1'b1;
    cyc(2000);
    checks++; if (led_o !== 4'b0000) begin errors++; $display("FAIL idle_led: got %b expected 0000", led_o); end
    checks++; if (mode_o !== 2'd0) begin errors++; $display("FAIL idle_mode: got %0d expected 0", mode_o); end
    checks++; if (rate_o !== 2'd2) begin errors++; $display("FAIL idle_rate: got %0d expected 2", rate_o); end
    press(2'b11);
    checks++; if (mode_o !== 2'd1 || rate_o !== 2'd3) begin errors++; $display("FAIL pre_reset_state: got mode %0d rate %0d expected mode 1 rate 3", mode_o, rate_o); end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (mode_o !== 2'd0 || rate_o !== 2'd2 || led_o !== 4'b0000) begin errors++; $display("FAIL async_reset: got mode %0d rate %0d led %b expected 0 2 0000", mode_o, rate_o, led_o); end
    cyc(3);
    rst_n = 1'b1;
    cyc(100);
    checks++; if (mode_o !== 2'd0 || rate_o !== 2'd2) begin errors++; $display("FAIL post_reset_no_event: got mode %0d rate %0d expected 0 2", mode_o, rate_o); end
  endtask

  task automatic test_debounce;
    int n;
    apply_reset();
    key = 2'b10;
    cyc(10);
    key = 2'b11;
    cyc(60);
    checks++; if (mode_o !== 2'd0) begin errors++; $display("FAIL glitch_mode: got %0d expected 0", mode_o); end
    key = 2'b10;
    n = 0;
    while (mode_o !== 2'd1 && n < 40) begin
      cyc(1);
      n++;
    end
    checks++; if (mode_o !== 2'd1 || n > 23 || n < 13) begin errors++; $display("FAIL press_latency: got mode %0d after %0d cycles expected mode 1 within 13..23", mode_o, n); end
    cyc(1);
    checks++; if (led_o !== 4'b1111) begin errors++; $display("FAIL on_led: got %b expected 1111", led_o); end
    key = 2'b11;
    cyc(60);
    checks++; if (mode_o !== 2'd1) begin errors++; $display("FAIL release_no_event: got %0d expected 1", mode_o); end
  endtask

  task automatic test_mode_wrap;
    logic [1:0] exp_mode [4];
    logic [3:0] exp_led [4];
    exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
    exp_led  = '{4'b1111, 4'b1111, 4'b0001, 4'b0000};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      press(2'b01);
      checks++; if (mode_o !== exp_mode[i]) begin errors++; $display("FAIL wrap_mode_%0d: got %0d expected %0d", i, mode_o, exp_mode[i]); end
      checks++; if (led_o !== exp_led[i]) begin errors++; $display("FAIL wrap_led_%0d: got %b expected %b", i, led_o, exp_led[i]); end
    end
  endtask

  task automatic test_blink;
    int n;
    apply_reset();
    press(2'b10);
    press(2'b10);
    checks++; if (rate_o !== 2'd0) begin errors++; $display("FAIL rate_wrap: got %0d expected 0", rate_o); end
    press(2'b01);
    press(2'b01);
    checks++; if (mode_o !== 2'd2 || led_o !== 4'b1111) begin errors++; $display("FAIL blink_start: got mode %0d led %b expected 2 1111", mode_o, led_o); end
    wait_led_change(1400, n);
    checks++; if (led_o !== 4'b0000) begin errors++; $display("FAIL blink_off: got %b expected 0000", led_o); end
    wait_led_change(1400, n);
    checks++; if (led_o !== 4'b1111 || n < 1249 || n > 1251) begin errors++; $display("FAIL blink_period_125: got led %b after %0d cycles expected 1111 after 1250", led_o, n); end
    wait_led_change(1400, n);
    checks++; if (led_o !== 4'b0000 || n < 1249 || n > 1251) begin errors++; $display("FAIL blink_period_125b: got led %b after %0d cycles expected 0000 after 1250", led_o, n); end
    press(2'b10);
    checks++; if (rate_o !== 2'd1 || led_o !== 4'b1111) begin errors++; $display("FAIL rate_change_restart: got rate %0d led %b expected 1 1111", rate_o, led_o); end
    wait_led_change(2600, n);
    checks++; if (led_o !== 4'b0000) begin errors++; $display("FAIL blink_off_250: got %b expected 0000", led_o); end
    wait_led_change(2600, n);
    checks++; if (led_o !== 4'b1111 || n < 2499 || n > 2501) begin errors++; $display("FAIL blink_period_250: got led %b after %0d cycles expected 1111 after 2500", led_o, n); end
  endtask

  task automatic test_chase;
    int n;
    logic [3:0] exp_led [4];
    exp_led = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    apply_reset();
    press(2'b10);
    press(2'b10);
    press(2'b01);
    press(2'b01);
    press(2'b01);
    checks++; if (mode_o !== 2'd3 || led_o !== 4'b0001) begin errors++; $display("FAIL chase_start: got mode %0d led %b expected 3 0001", mode_o, led_o); end
    for (int i = 0; i < 4; i++) begin
      wait_led_change(1400, n);
      checks++; if (led_o !== exp_led[i]) begin errors++; $display("FAIL chase_step_%0d: got %b expected %b", i, led_o, exp_led[i]); end
      if (i > 0) begin
        checks++; if (n < 1249 || n > 1251) begin errors++; $display("FAIL chase_period_%0d: got %0d cycles expected 1250", i, n); end
      end
    end
    key = 2'b00;
    n = 0;
    while (mode_o === 2'd3 && n < 40) begin
      cyc(1);
      n++;
    end
    checks++; if (mode_o !== 2'd0 || rate_o !== 2'd1) begin errors++; $display("FAIL simultaneous_keys: got mode %0d rate %0d expected 0 1", mode_o, rate_o); end
    cyc(1);
    checks++; if (led_o !== 4'b0000) begin errors++; $display("FAIL simultaneous_led: got %b expected 0000", led_o); end
    key = 2'b11;
    cyc(60);
  endtask

`ifdef LED_LONGPRESS_EN
  task automatic test_longpress;
    int n;
    apply_reset();
    press(2'b10);
    press(2'b10);
    press(2'b01);
    press(2'b01);
    press(2'b01);
    key = 2'b10;
    n = 0;
    while (mode_o !== 2'd0 && n < 40) begin
      cyc(1);
      n++;
    end
    checks++; if (mode_o !== 2'd0 || rate_o !== 2'd0) begin errors++; $display("FAIL longpress_short_action: got mode %0d rate %0d expected 0 0", mode_o, rate_o); end
    n = 0;
    while (rate_o !== 2'd2 && n < 11000) begin
      cyc(1);
      n++;
    end
    checks++; if (rate_o !== 2'd2 || mode_o !== 2'd0 || n < 9980 || n > 10020) begin errors++; $display("FAIL longpress_fire: got rate %0d mode %0d after %0d cycles expected 2 0 after ~10000", rate_o, mode_o, n); end
    cyc(2000);
    checks++; if (rate_o !== 2'd2 || mode_o !== 2'd0) begin errors++; $display("FAIL longpress_once: got rate %0d mode %0d expected 2 0", rate_o, mode_o); end
    key = 2'b11;
    cyc(60);
  endtask
`endif

  initial begin
    key   = 2'b11;
    rst_n = 1'b0;
    test_reset();
    test_debounce();
    test_mode_wrap();
    test_blink();
    test_chase();
`ifdef LED_LONGPRESS_EN
    test_longpress();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
